// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM state encoding and request payload for the SRAM arbiter.
// The arbiter top and the round-robin picker both build on these definitions.
package sram_arb_pkg;

    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 32;
    localparam int NUM_LANES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [NUM_LANES-1:0] we;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    wdata;
    } req_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin picker; remembers which requester was granted last.
// A lone requester always wins, and under contention the other one goes first.
module sram_rr_arb (
    input  logic       i_clock,
    input  logic       i_resetN,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic r_lastGnt;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_lastGnt ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    // Resetting to requester 1 means requester 0 wins the first contended cycle.
    always_ff @(posedge i_clock) begin
        if (!i_resetN) begin
            r_lastGnt <= 1'b1;
        end else if (|o_gnt) begin
            r_lastGnt <= o_gnt[1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one byte-writable single-port SRAM between two pipelined requesters
// and adds a clear engine that zero-fills a wrapping address range.
module sram_arbiter #(
    parameter int ADDR_W = sram_arb_pkg::ADDR_W,
    parameter int DATA_W = sram_arb_pkg::DATA_W
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [1:0]          m_req,
    input  logic [7:0]          m_we,
    input  logic [2*ADDR_W-1:0] m_addr,
    input  logic [2*DATA_W-1:0] m_wdata,
    output logic [1:0]          m_gnt,
    output logic [1:0]          m_rvalid,
    output logic [DATA_W-1:0]   m_rdata,
    input  logic                clr_start,
    input  logic [ADDR_W-1:0]   clr_base,
    input  logic [ADDR_W:0]     clr_len,
    output logic                clr_busy,
    output logic                clr_done,
    output logic                sram_cs,
    output logic                sram_oe,
    output logic [3:0]          sram_web,
    output logic [ADDR_W-1:0]   sram_a,
    output logic [DATA_W-1:0]   sram_di,
    input  logic [DATA_W-1:0]   sram_do
);

    import sram_arb_pkg::state_t;
    import sram_arb_pkg::req_t;
    import sram_arb_pkg::IDLE;
    import sram_arb_pkg::CLEAR;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_nextCount;
    logic [ADDR_W-1:0] r_clrBase;
    logic [ADDR_W:0]   r_clrLen;
    logic              r_rspValid;
    logic              r_rspOwner;
    logic              r_clrDone;
    logic              w_doneNext;
    logic              w_arbEn;
    logic [1:0]        w_gnt;
    req_t              w_winner;

    // A clr_start in IDLE takes the cycle even when it turns out to be empty.
    assign w_arbEn = ARESETn && (r_state == IDLE) && !clr_start;

    sram_rr_arb u_rrArb (
        .i_clock  (ACLK),
        .i_resetN (ARESETn),
        .i_req    (m_req),
        .i_en     (w_arbEn),
        .o_gnt    (w_gnt)
    );

    always_comb begin
        w_winner.we    = w_gnt[1] ? m_we[7:4]                  : m_we[3:0];
        w_winner.addr  = w_gnt[1] ? m_addr[2*ADDR_W-1:ADDR_W]  : m_addr[ADDR_W-1:0];
        w_winner.wdata = w_gnt[1] ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_doneNext  = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr_start) begin
                    if (clr_len != '0) begin
                        w_nextState = CLEAR;
                        w_nextCount = '0;
                    end else begin
                        w_doneNext = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (r_count == r_clrLen - 1'b1) begin
                    w_nextState = IDLE;
                    w_doneNext  = 1'b1;
                end else begin
                    w_nextCount = r_count + 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Every output is forced to its idle value while reset is held low.
    always_comb begin
        m_gnt    = 2'b00;
        sram_cs  = 1'b0;
        sram_web = 4'hF;
        sram_a   = '0;
        sram_di  = '0;
        if (ARESETn) begin
            if (r_state == CLEAR) begin
                sram_cs  = 1'b1;
                sram_web = 4'h0;
                sram_a   = r_clrBase + r_count[ADDR_W-1:0];
            end else if (|w_gnt) begin
                m_gnt    = w_gnt;
                sram_cs  = 1'b1;
                sram_web = ~w_winner.we;
                sram_a   = w_winner.addr;
                sram_di  = w_winner.wdata;
            end
        end
    end

    always_comb begin
        m_rvalid = 2'b00;
        m_rdata  = '0;
        sram_oe  = 1'b0;
        if (ARESETn && r_rspValid) begin
            m_rvalid[r_rspOwner] = 1'b1;
            m_rdata              = sram_do;
            sram_oe              = 1'b1;
        end
    end

    assign clr_busy = ARESETn && (r_state == CLEAR);
    assign clr_done = ARESETn && r_clrDone;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_clrBase  <= '0;
            r_clrLen   <= '0;
            r_rspValid <= 1'b0;
            r_rspOwner <= 1'b0;
            r_clrDone  <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_count    <= w_nextCount;
            r_clrDone  <= w_doneNext;
            r_rspValid <= (|w_gnt) && (w_winner.we == 4'h0);
            r_rspOwner <= w_gnt[1];
            if (r_state == IDLE && clr_start) begin
                r_clrBase <= clr_base;
                r_clrLen  <= clr_len;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and a scoreboard
// that matches every read response and every clear write against queued expectations.
module tb_sram_arbiter;

    logic        ACLK;
    logic        ARESETn;
    logic [1:0]  m_req;
    logic [7:0]  m_we;
    logic [37:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_gnt;
    logic [1:0]  m_rvalid;
    logic [31:0] m_rdata;
    logic        clr_start;
    logic [18:0] clr_base;
    logic [19:0] clr_len;
    logic        clr_busy;
    logic        clr_done;
    logic        sram_cs;
    logic        sram_oe;
    logic [3:0]  sram_web;
    logic [18:0] sram_a;
    logic [31:0] sram_di;
    logic [31:0] sram_do;

    int testsRun  = 0;
    int testsFail = 0;
    int doneCount = 0;

    logic [31:0] expRsp0 [$];
    logic [31:0] expRsp1 [$];
    logic [18:0] expClr  [$];
    logic [31:0] mem [logic [18:0]];

    sram_arbiter dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_gnt     (m_gnt),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .clr_start (clr_start),
        .clr_base  (clr_base),
        .clr_len   (clr_len),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .sram_cs   (sram_cs),
        .sram_oe   (sram_oe),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_di   (sram_di),
        .sram_do   (sram_do)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Byte-writable SRAM with registered read data; unwritten words read as zero.
    always @(posedge ACLK) begin
        logic [31:0] word;
        if (sram_cs) begin
            word = mem.exists(sram_a) ? mem[sram_a] : 32'h0;
            if (sram_web == 4'hF) begin
                sram_do <= word;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (!sram_web[b]) word[b*8 +: 8] = sram_di[b*8 +: 8];
                mem[sram_a] = word;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: read responses and clear writes are popped as they appear.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (m_rvalid[0]) begin
                if (expRsp0.size() == 0) checkOutput("unexpected rvalid0", 32'd1, 32'd0);
                else checkOutput("rdata m0", m_rdata, expRsp0.pop_front());
            end
            if (m_rvalid[1]) begin
                if (expRsp1.size() == 0) checkOutput("unexpected rvalid1", 32'd1, 32'd0);
                else checkOutput("rdata m1", m_rdata, expRsp1.pop_front());
            end
            if (clr_busy) begin
                if (expClr.size() == 0) checkOutput("unexpected clear write", 32'd1, 32'd0);
                else checkOutput("clear addr", {13'h0, sram_a}, {13'h0, expClr.pop_front()});
                checkOutput("clear web/cs/di", {sram_di[27:0], sram_web}, 32'h0);
            end
            if (clr_done) doneCount++;
        end
    end

    task automatic applyStimulus(input int m, input logic [3:0] we, input logic [18:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expData);
        int waited = 0;
        m_req[m]             = 1'b1;
        m_we[m*4 +: 4]       = we;
        m_addr[m*19 +: 19]   = addr;
        m_wdata[m*32 +: 32]  = wdata;
        do begin
            @(negedge ACLK);
            waited++;
        end while (!m_gnt[m] && waited < 20);
        checkOutput($sformatf("gnt m%0d", m), {30'h0, m_gnt}, (m == 0) ? 32'd1 : 32'd2);
        if (we == 4'h0) begin
            if (m == 0) expRsp0.push_back(expData);
            else        expRsp1.push_back(expData);
        end
        @(posedge ACLK); #1;
        m_req[m] = 1'b0;
        @(negedge ACLK);
        checkOutput($sformatf("rvalid after m%0d access", m), {30'h0, m_rvalid},
                    (we == 4'h0) ? ((m == 0) ? 32'd1 : 32'd2) : 32'd0);
        @(posedge ACLK); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0] gntSeq [4];
        gntSeq[0] = 2'b01; gntSeq[1] = 2'b10; gntSeq[2] = 2'b01; gntSeq[3] = 2'b10;

        // Reset with both requesters asking.
        ARESETn   = 1'b0;
        m_req     = 2'b11;
        m_we      = 8'hFF;
        m_addr    = '0;
        m_wdata   = 64'h1234_5678_9ABC_DEF0;
        clr_start = 1'b0;
        clr_base  = '0;
        clr_len   = '0;
        @(posedge ACLK); @(posedge ACLK);
        @(negedge ACLK);
        checkOutput("reset m_gnt", {30'h0, m_gnt}, 32'd0);
        checkOutput("reset sram_cs/oe", {30'h0, sram_cs, sram_oe}, 32'd0);
        checkOutput("reset sram_web", {28'h0, sram_web}, 32'hF);
        checkOutput("reset m_rvalid", {30'h0, m_rvalid}, 32'd0);
        checkOutput("reset clr_busy/done", {30'h0, clr_busy, clr_done}, 32'd0);
        checkOutput("reset sram_a", {13'h0, sram_a}, 32'd0);
        checkOutput("reset sram_di", sram_di, 32'd0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        m_req   = 2'b00;

        // Full write then read by M0.
        applyStimulus(0, 4'hF, 19'h00010, 32'hDEADBEEF, 32'h0);
        applyStimulus(0, 4'h0, 19'h00010, 32'h0, 32'hDEADBEEF);
        @(negedge ACLK);
        checkOutput("idle m_rdata", m_rdata, 32'd0);
        @(posedge ACLK); #1;

        // Single-lane write by M1 merges into the existing word.
        applyStimulus(1, 4'b0010, 19'h00010, 32'h0000AA00, 32'h0);
        applyStimulus(1, 4'h0, 19'h00010, 32'h0, 32'hDEADAAEF);
        applyStimulus(1, 4'hF, 19'h00020, 32'h12345678, 32'h0);

        // Both reading continuously: alternating grants, back-to-back responses.
        m_we    = 8'h00;
        m_addr  = {19'h00020, 19'h00010};
        m_req   = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            checkOutput($sformatf("rr gnt %0d", i), {30'h0, m_gnt}, {30'h0, gntSeq[i]});
            if (gntSeq[i][0]) expRsp0.push_back(32'hDEADAAEF);
            else              expRsp1.push_back(32'h12345678);
            if (i > 0) checkOutput($sformatf("rr rvalid %0d", i), {30'h0, m_rvalid}, {30'h0, gntSeq[i-1]});
            @(posedge ACLK); #1;
        end
        m_req = 2'b00;
        @(negedge ACLK);
        checkOutput("rr last rvalid", {30'h0, m_rvalid}, {30'h0, gntSeq[3]});
        @(posedge ACLK); #1;

        // Wrapping clear while M0 waits to read a previously non-zero word.
        applyStimulus(0, 4'hF, 19'h00000, 32'h11111111, 32'h0);
        expClr.push_back(19'h7FFFE); expClr.push_back(19'h7FFFF);
        expClr.push_back(19'h00000); expClr.push_back(19'h00001);
        clr_start = 1'b1;
        clr_base  = 19'h7FFFE;
        clr_len   = 20'd4;
        m_we      = 8'h00;
        m_addr    = {19'h0, 19'h00000};
        m_req     = 2'b01;
        @(negedge ACLK);
        checkOutput("clr start stall", {29'h0, m_gnt, sram_cs}, 32'd0);
        @(posedge ACLK); #1;
        clr_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            checkOutput($sformatf("clear cycle %0d gnt/busy/done", i),
                        {28'h0, m_gnt, clr_busy, clr_done}, 32'd2);
        end
        @(negedge ACLK);
        checkOutput("clear done pulse", {30'h0, clr_busy, clr_done}, 32'd1);
        checkOutput("m0 granted after clear", {30'h0, m_gnt}, 32'd1);
        expRsp0.push_back(32'h0);
        @(posedge ACLK); #1;
        m_req = 2'b00;
        @(negedge ACLK);
        checkOutput("clr_done single pulse", {31'h0, clr_done}, 32'd0);
        checkOutput("cleared read rvalid", {30'h0, m_rvalid}, 32'd1);
        @(posedge ACLK); #1;

        // Zero-length clear: done next cycle, SRAM untouched.
        clr_start = 1'b1;
        clr_base  = 19'h00040;
        clr_len   = 20'd0;
        @(negedge ACLK);
        checkOutput("len0 start cs/busy", {30'h0, sram_cs, clr_busy}, 32'd0);
        @(posedge ACLK); #1;
        clr_start = 1'b0;
        @(negedge ACLK);
        checkOutput("len0 done/cs/busy", {29'h0, clr_done, sram_cs, clr_busy}, 32'd4);
        @(posedge ACLK); #1;

        // Reset in the second cycle of a len-8 clear aborts it silently.
        expClr.push_back(19'h00100);
        clr_start = 1'b1;
        clr_base  = 19'h00100;
        clr_len   = 20'd8;
        @(posedge ACLK); #1;
        clr_start = 1'b0;
        @(negedge ACLK);
        checkOutput("abort first cycle busy", {31'h0, clr_busy}, 32'd1);
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        @(negedge ACLK);
        checkOutput("abort in reset busy/cs", {30'h0, clr_busy, sram_cs}, 32'd0);
        @(posedge ACLK); @(posedge ACLK); #1;
        ARESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            checkOutput($sformatf("post abort %0d busy/done/cs", i),
                        {29'h0, clr_busy, clr_done, sram_cs}, 32'd0);
        end

        checkOutput("clr_done pulse count", doneCount, 32'd2);
        checkOutput("pending responses", expRsp0.size() + expRsp1.size(), 32'd0);
        checkOutput("pending clear writes", expClr.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences the single-port 512K x 32 byte-writable SRAM macro (19-bit address, CS/OE active-high, per-byte WEB active-low, registered read data) and shares it between two requesters, e.g. the instruction-fetch and data ports of a wrapper.
- Provides a pipelined req/gnt/rvalid interface with one access per cycle and round-robin fairness.
- Includes a hardware clear engine that zero-fills an address range.

Parameters:
- ADDR_W, 19, SRAM word-address width.
- DATA_W, 32, data width; must equal 4 x 8 byte lanes.

Ports:
- ACLK  in  1  clock; drives the SRAM CK.
- ARESETn  in  1  reset, synchronous, active-low.
- m_req  in  2  per-requester access request; hold with payload until granted.
- m_we  in  2x4  per-requester byte write enables, active-high; 4'h0 means read.
- m_addr  in  2xADDR_W  per-requester word address.
- m_wdata  in  2xDATA_W  per-requester write data.
- m_gnt  out  2  one-hot grant; the access is issued in the same cycle.
- m_rvalid  out  2  read data valid for the owning requester.
- m_rdata  out  DATA_W  read data, shared; qualified by m_rvalid.
- clr_start  in  1  pulse that starts the clear engine.
- clr_base  in  ADDR_W  first word to clear.
- clr_len  in  ADDR_W+1  number of words to clear.
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse when a clear finishes.
- sram_cs  out  1  SRAM chip select.
- sram_oe  out  1  SRAM output enable.
- sram_web  out  4  SRAM byte write enables, active-low.
- sram_a  out  ADDR_W  SRAM address.
- sram_di  out  DATA_W  SRAM write data.
- sram_do  in  DATA_W  SRAM read data.

Behaviour:
- Reset: all synchronous; takes effect on the ACLK edge while ARESETn=0.
  - FSM goes to IDLE, any pending response is dropped, last_gnt=1 (so M0 wins first).
  - Required values while ARESETn=0: m_gnt=0, m_rvalid=0, clr_busy=0, clr_done=0, sram_cs=0, sram_oe=0, sram_web=4'hF, sram_a=0, sram_di=0.
- FSM states: IDLE and CLEAR.
  - IDLE to CLEAR: clr_start=1 and clr_len!=0.
  - CLEAR to IDLE: after the last clear write.
  - clr_start with clr_len=0: no SRAM activity; clr_done pulses on the next cycle.
- Arbitration (IDLE only, combinational):
  - One requester active: grant it.
  - Both active: grant the one other than last_grant.
  - last_grant updates on every grant.
- Grant cycle: sram_cs=1; sram_a, sram_di and sram_web=~m_we come from the winner. The SRAM samples on the ending edge.
- Read latency: 1 cycle. In the cycle after a read grant:
  - resp_valid=1, sram_oe=1;
  - m_rvalid[owner]=1 and m_rdata=sram_do.
  - A new grant may issue in the same cycle, giving back-to-back throughput of 1 access/cycle.
- Writes: no response. Partial m_we writes only the enabled lanes. m_rdata=0 when no response is pending.
- CLEAR:
  - Each cycle: sram_cs=1, sram_web=4'h0, sram_di=0, sram_a=clr_base+count (mod 2^ADDR_W, so it wraps).
  - count runs from 0 to clr_len-1.
  - clr_busy=1 throughout; m_gnt=0.
  - clr_done pulses in the cycle after the last write.
- Simultaneous events:
  - clr_start and m_req in the same IDLE cycle: clear wins; requests stall.
  - A read granted in the prior cycle still returns its m_rvalid during the first CLEAR cycle.
  - clr_start during CLEAR is ignored.
  - Reset during CLEAR aborts it; clr_done is not pulsed.

Decomposition:
- Shared package sram_arb_pkg: ADDR_W/DATA_W constants, state enum (IDLE, CLEAR), request struct {we, addr, wdata}.
- One sub-module: sram_rr_arb, a 2-way round-robin picker holding the last_grant register.

Test Plan:
1. ARESETn=0 for 2 cycles with m_req=2'b11 -> m_gnt=0, sram_cs=0, sram_web=4'hF, m_rvalid=0, clr_done=0.
2. M0 writes 0xDEADBEEF to 0x00010 with we=4'hF, then reads 0x00010 -> m_gnt[0] asserted each cycle; m_rvalid[0] one cycle after the read grant; m_rdata=0xDEADBEEF.
3. Then M1 writes 0x0000AA00 to 0x00010 with we=4'b0010, and M1 reads 0x00010 -> m_rdata=0xDEADAAEF.
4. Both requesters read continuously -> m_gnt sequence 01,10,01,10 (M0 first); m_rvalid follows one cycle later, with no idle cycles.
5. clr_start with base 0x7FFFE, len 4, while M0 is requesting:
   - writes go to 0x7FFFE, 0x7FFFF, 0x00000, 0x00001; M0 stalls for 4 cycles;
   - clr_done pulses once; a later read of 0x00000 returns 0.
6. clr_len=0 -> clr_done the next cycle with no sram_cs. Separately, ARESETn=0 in the 2nd cycle of a len-8 clear -> clr_busy=0 and no clr_done pulse.
